queue_arbiter: RTL and testbench



---
 rtl/queue_arbiter.sv | 136 +++++++++++++
 tb/tb_queue_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/queue_arbiter.sv
// Arbiter sharing one 8-entry queue between NUM_REQ round-robin pushers and a single popper.
// Optional saturating statistics counters are built when QARB_STATS_EN is defined.
module queue_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 4
) (
  input  logic                        clk,
  input  logic                        rst_p,
  input  logic [NUM_REQ-1:0]          push_req,
  input  logic [NUM_REQ*DATA_W-1:0]   push_data,
  output logic [NUM_REQ-1:0]          push_ack,
  input  logic                        pop_req,
  output logic                        pop_ack,
  output logic [DATA_W-1:0]           pop_data,
  output logic                        q_enable,
  output logic                        q_push_pop,
  output logic [DATA_W-1:0]           q_data_in,
  input  logic [DATA_W-1:0]           q_data_out,
  input  logic                        q_full,
  input  logic                        q_empty,
  output logic [7:0]                  stat_push_cnt,
  output logic [7:0]                  stat_pop_cnt,
  output logic [7:0]                  stat_stall_cnt
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PTR_W = 3;

  typedef enum logic {ARB, POP_RSP} state_t;

  state_t              state;
  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    rr_next;
  logic                pref_pop;
  logic                pop_ack_q;
  logic [NUM_REQ-1:0]  push_elig;
  logic                pop_elig;
  logic                sel_found;
  logic [IDX_W-1:0]    sel_idx;
  int unsigned         scan_idx;
  logic                grant_push;
  logic                grant_pop;
  logic [DATA_W-1:0]   data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_data
    assign data_arr[g] = push_data[g*DATA_W +: DATA_W];
  end

  assign push_elig = push_req & {NUM_REQ{~q_full}};
  assign pop_elig  = pop_req & ~q_empty & (state == ARB);

  // Round-robin scan starting at rr_ptr
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    scan_idx  = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = (32'(rr_ptr) + k) % NUM_REQ;
      if (!sel_found && push_elig[IDX_W'(scan_idx)]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(scan_idx);
      end
    end
  end

  assign rr_next = PTR_W'((32'(sel_idx) + 32'd1) % NUM_REQ);

  // Class choice; reset gates every command off
  assign grant_push = ~rst_p & sel_found & (~pop_elig | ~pref_pop);
  assign grant_pop  = ~rst_p & pop_elig & (~sel_found | pref_pop);

  always_comb begin
    push_ack   = '0;
    q_enable   = grant_push | grant_pop;
    q_push_pop = grant_push;
    q_data_in  = '0;
    if (grant_push) begin
      push_ack[sel_idx] = 1'b1;
      q_data_in         = data_arr[sel_idx];
    end
  end

  // Arbitration state and registered pop response
  always_ff @(posedge clk) begin
    if (rst_p) begin
      state     <= ARB;
      rr_ptr    <= '0;
      pref_pop  <= 1'b0;
      pop_ack_q <= 1'b0;
      pop_data  <= '0;
    end else begin
      pop_ack_q <= grant_pop;
      case (state)
        ARB: begin
          if (grant_pop) begin
            state    <= POP_RSP;
            pop_data <= q_data_out;
          end
        end
        POP_RSP: state <= ARB;
      endcase
      if (grant_push) begin
        rr_ptr   <= rr_next;
        pref_pop <= 1'b1;
      end else if (grant_pop) begin
        pref_pop <= 1'b0;
      end
    end
  end

  // A reset landing on the response cycle swallows the pending acknowledge
  assign pop_ack = pop_ack_q & ~rst_p;

`ifdef QARB_STATS_EN
  logic any_req;
  assign any_req = (|push_req) | pop_req;

  always_ff @(posedge clk) begin
    if (rst_p) begin
      stat_push_cnt  <= '0;
      stat_pop_cnt   <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (grant_push && stat_push_cnt != 8'hFF) stat_push_cnt <= stat_push_cnt + 8'd1;
      if (grant_pop && stat_pop_cnt != 8'hFF) stat_pop_cnt <= stat_pop_cnt + 8'd1;
      if (any_req && !q_enable && stat_stall_cnt != 8'hFF)
        stat_stall_cnt <= stat_stall_cnt + 8'd1;
    end
  end
`else
  assign stat_push_cnt  = '0;
  assign stat_pop_cnt   = '0;
  assign stat_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_queue_arbiter.sv
// Randomized scoreboard bench for queue_arbiter with a behavioural queue and arbitration model.
module tb_queue_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 4;
  localparam int QDEPTH  = 8;

  logic                       clk;
  logic                       rst_p;
  logic [NUM_REQ-1:0]         push_req;
  logic [NUM_REQ*DATA_W-1:0]  push_data;
  logic [NUM_REQ-1:0]         push_ack;
  logic                       pop_req;
  logic                       pop_ack;
  logic [DATA_W-1:0]          pop_data;
  logic                       q_enable;
  logic                       q_push_pop;
  logic [DATA_W-1:0]          q_data_in;
  logic [DATA_W-1:0]          q_data_out;
  logic                       q_full;
  logic                       q_empty;
  logic [7:0]                 stat_push_cnt;
  logic [7:0]                 stat_pop_cnt;
  logic [7:0]                 stat_stall_cnt;

  queue_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_p(rst_p),
    .push_req(push_req), .push_data(push_data), .push_ack(push_ack),
    .pop_req(pop_req), .pop_ack(pop_ack), .pop_data(pop_data),
    .q_enable(q_enable), .q_push_pop(q_push_pop), .q_data_in(q_data_in),
    .q_data_out(q_data_out), .q_full(q_full), .q_empty(q_empty),
    .stat_push_cnt(stat_push_cnt), .stat_pop_cnt(stat_pop_cnt),
    .stat_stall_cnt(stat_stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [NUM_REQ-1:0] ack;
    logic               en;
    logic               pp;
    logic [DATA_W-1:0]  din;
    logic               pa;
    logic [7:0]         sp;
    logic [7:0]         so;
    logic [7:0]         ss;
  } exp_t;

  int checks = 0;
  int errors = 0;

  exp_t              exp_q[$];
  logic [DATA_W-1:0] exp_pop[$];
  logic [DATA_W-1:0] env_q[$];
  logic [DATA_W-1:0] m_q[$];

  // requester intent
  logic [NUM_REQ-1:0] preq = '0;
  logic [DATA_W-1:0]  pdat [NUM_REQ];
  logic               popr = 1'b0;

  // model state
  int m_rr = 0;
  bit m_pref = 0;
  bit m_rsp = 0;
  int m_sp = 0, m_so = 0, m_ss = 0;

  // last observed DUT outputs
  logic               obs_en = 1'b0, obs_pp = 1'b0, obs_pa = 1'b0;
  logic [DATA_W-1:0]  obs_din = '0;
  logic [NUM_REQ-1:0] obs_ack = '0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  // Reference: one arbitration decision per cycle from queue occupancy and requests
  task automatic model(input bit rst);
    exp_t e;
    int   sel;
    bit   pop_ok, full, empty;
    e.ack = '0; e.en = 0; e.pp = 0; e.din = '0; e.pa = 0;
`ifdef QARB_STATS_EN
    e.sp = 8'(m_sp); e.so = 8'(m_so); e.ss = 8'(m_ss);
`else
    e.sp = '0; e.so = '0; e.ss = '0;
`endif
    if (rst) begin
      if (m_rsp && exp_pop.size() > 0) void'(exp_pop.pop_back());
      m_rr = 0; m_pref = 0; m_rsp = 0; m_sp = 0; m_so = 0; m_ss = 0;
    end else begin
      e.pa  = m_rsp;
      full  = (m_q.size() >= QDEPTH);
      empty = (m_q.size() == 0);
      sel   = -1;
      if (!full)
        for (int k = 0; k < NUM_REQ; k++) begin
          int i;
          i = (m_rr + k) % NUM_REQ;
          if (sel < 0 && preq[i]) sel = i;
        end
      pop_ok = popr && !empty && !m_rsp;
      m_rsp  = 0;
      if (sel >= 0 && !(pop_ok && m_pref)) begin
        e.ack[sel] = 1'b1; e.en = 1; e.pp = 1; e.din = pdat[sel];
        m_q.push_back(pdat[sel]);
        m_rr = (sel + 1) % NUM_REQ; m_pref = 1; m_sp = sat_inc(m_sp);
      end else if (pop_ok) begin
        e.en = 1;
        exp_pop.push_back(m_q.pop_front());
        m_pref = 0; m_rsp = 1; m_so = sat_inc(m_so);
      end else if ((|preq) || popr) begin
        m_ss = sat_inc(m_ss);
      end
    end
    exp_q.push_back(e);
  endtask

  // One cycle: queue environment update, requester behaviour, model expectation
  task automatic step(input bit rst, input int push_pct, input int pop_pct);
    @(posedge clk);
    #1;
    if (obs_en) begin
      if (obs_pp) begin
        chk("push_when_full", int'(env_q.size() < QDEPTH), 1);
        if (env_q.size() < QDEPTH) env_q.push_back(obs_din);
      end else begin
        chk("pop_when_empty", int'(env_q.size() > 0), 1);
        if (env_q.size() > 0) void'(env_q.pop_front());
      end
    end
    rst_p = rst;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (obs_ack[i]) preq[i] = 1'b0;
      if (!preq[i] && int'($urandom_range(99)) < push_pct) begin
        preq[i] = 1'b1;
        pdat[i] = DATA_W'($urandom_range(15));
      end
    end
    if (obs_pa) popr = 1'b0;
    if (!popr && int'($urandom_range(99)) < pop_pct) popr = 1'b1;
    push_req = preq;
    for (int i = 0; i < NUM_REQ; i++) push_data[i*DATA_W +: DATA_W] = pdat[i];
    pop_req    = popr;
    q_full     = (env_q.size() >= QDEPTH);
    q_empty    = (env_q.size() == 0);
    q_data_out = (env_q.size() > 0) ? env_q[0] : '0;
    model(rst);
  endtask

  // Monitor: compare each presented cycle against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    obs_en = q_enable; obs_pp = q_push_pop; obs_din = q_data_in;
    obs_ack = push_ack; obs_pa = pop_ack;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("push_ack", int'(push_ack), int'(e.ack));
      chk("q_enable", int'(q_enable), int'(e.en));
      chk("q_push_pop", int'(q_push_pop), int'(e.pp));
      chk("q_data_in", int'(q_data_in), int'(e.din));
      chk("pop_ack", int'(pop_ack), int'(e.pa));
      chk("stat_push_cnt", int'(stat_push_cnt), int'(e.sp));
      chk("stat_pop_cnt", int'(stat_pop_cnt), int'(e.so));
      chk("stat_stall_cnt", int'(stat_stall_cnt), int'(e.ss));
      if (pop_ack && e.pa) begin
        if (exp_pop.size() > 0) chk("pop_data", int'(pop_data), int'(exp_pop.pop_front()));
        else chk("pop_data_unexpected", 1, 0);
      end
    end
  end

  initial begin
    bit granted;
    rst_p = 1'b1; push_req = '0; push_data = '0; pop_req = 1'b0;
    q_full = 1'b0; q_empty = 1'b1; q_data_out = '0;
    for (int i = 0; i < NUM_REQ; i++) pdat[i] = '0;

    repeat (3) step(1, 0, 0);
    @(negedge clk);
    chk("reset_pop_data", int'(pop_data), 0);

    // four simultaneous pushers on an empty queue
    for (int i = 0; i < NUM_REQ; i++) begin preq[i] = 1'b1; pdat[i] = DATA_W'(i + 1); end
    repeat (6) step(0, 0, 0);

    // fill the queue, stall pushers, then release one slot with a pop
    repeat (12) step(0, 100, 0);
    popr = 1'b1;
    repeat (6) step(0, 100, 0);

    // drain, then pop waits on an empty queue until a single push of 9
    repeat (40) step(0, 0, 100);
    preq = '0; popr = 1'b1;
    repeat (10) step(0, 0, 0);
    preq[1] = 1'b1; pdat[1] = 4'd9;
    repeat (5) step(0, 0, 0);

    // mixed random traffic
    repeat (300) step(0, 60, 50);

    // reset in the response cycle of a pop
    preq = '0; popr = 1'b0;
    repeat (2) step(0, 0, 0);
    preq[0] = 1'b1; pdat[0] = 4'd7;
    repeat (3) step(0, 0, 0);
    popr = 1'b1;
    granted = 0;
    for (int n = 0; n < 20 && !granted; n++) begin
      step(0, 0, 0);
      granted = m_rsp;
    end
    chk("pop_grant_before_reset", int'(granted), 1);
    repeat (2) step(1, 0, 0);
    repeat (3) step(0, 0, 0);

    // long run to saturate the statistics
    repeat (2000) step(0, 80, 80);
    repeat (3) step(0, 0, 0);
    @(negedge clk);
    #1;
`ifdef QARB_STATS_EN
    chk("stat_push_saturated", int'(stat_push_cnt), 255);
    chk("stat_pop_saturated", int'(stat_pop_cnt), 255);
`else
    chk("stat_push_zero", int'(stat_push_cnt), 0);
    chk("stat_pop_zero", int'(stat_pop_cnt), 0);
    chk("stat_stall_zero", int'(stat_stall_cnt), 0);
`endif
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
